// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit. Each RUN cycle adds one CHUNK-bit slice, LSB first,
// and a carry register links the slices. Results and flags are held in DONE until accepted.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
  logic             op_q, a_msb, b_msb, carry_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   csum;
  logic             last;

  // One ripple slice per cycle; res_nx already holds the final slice on the DONE-entry edge.
  always_comb begin
    csum   = {1'b0, a_q[cnt*CHUNK +: CHUNK]} + {1'b0, b_q[cnt*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, carry_q};
    res_nx = res_q;
    res_nx[cnt*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    last   = (cnt == CW'(NCHUNK - 1));
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_q     <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= op_sub ? ~B : B;
            op_q    <= op_sub;
            a_msb   <= A[WIDTH-1];
            b_msb   <= B[WIDTH-1];
            carry_q <= op_sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          res_q   <= res_nx;
          carry_q <= csum[CHUNK];
          cnt     <= cnt + CW'(1);
          if (last) begin
            Carry    <= op_q ^ csum[CHUNK];
            // Operand signs must match for add and differ for sub (original B).
            Overflow <= ((a_msb ^ b_msb) == op_q) && (res_nx[WIDTH-1] != a_msb);
            Zero     <= ~|res_nx;
            Negative <= res_nx[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign Result = res_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: an 8-bit/4-bit instance for the main cases, and
// five 16-bit instances (CHUNK 1,2,4,8,16) run in lockstep against a reference model.
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       iv8, or8, op8, ir8, ov8, c8, v8, z8, n8;
  logic [7:0] a8, b8, res8;

  logic        ivw, orw, opw;
  logic [15:0] aw, bw;
  logic [4:0]  irw, ovw, cw, vw, zw, nw;
  logic [15:0] resw [5];
  int          chs [5] = '{1, 2, 4, 8, 16};

  addsub_seq #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op_sub(op8),
    .A(a8), .B(b8), .out_valid(ov8), .out_ready(or8), .Result(res8),
    .Carry(c8), .Overflow(v8), .Zero(z8), .Negative(n8)
  );

  for (genvar g = 0; g < 5; g++) begin : g_w
    localparam int CH = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 16;
    addsub_seq #(.WIDTH(16), .CHUNK(CH)) u (
      .clk(clk), .rst_n(rst_n), .in_valid(ivw), .in_ready(irw[g]), .op_sub(opw),
      .A(aw), .B(bw), .out_valid(ovw[g]), .out_ready(orw), .Result(resw[g]),
      .Carry(cw[g]), .Overflow(vw[g]), .Zero(zw[g]), .Negative(nw[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 8-bit unit and wait for out_valid; inputs are scrambled after accept.
  task automatic go8(input logic op, input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    chk("in_ready_idle", ir8, 1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; op8 = ~op; a8 = ~a; b8 = ~b;
    n = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency8", n, 2);
  endtask

  task automatic res8_chk(input logic [7:0] r, input logic c, input logic v,
                          input logic z, input logic ng);
    chk("result8", res8, r);
    chk("carry8", c8, c);
    chk("ovf8", v8, v);
    chk("zero8", z8, z);
    chk("neg8", n8, ng);
  endtask

  task automatic pop8();
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("pop8_valid", ov8, 0);
    chk("pop8_ready", ir8, 1);
  endtask

  // Reference: {carry, overflow, zero, negative, result}
  function automatic logic [19:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, t;
    logic [16:0] s;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = op ? sa - sb : sa + sb;
    v  = (t > 32767) || (t < -32768);
    if (op) begin
      s = {1'b0, a} - {1'b0, b};
      c = (a < b);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      c = s[16];
    end
    return {c, v, (s[15:0] == 16'h0), s[15], s[15:0]};
  endfunction

  task automatic go16(input logic op, input logic [15:0] a, input logic [15:0] b);
    int n;
    int lat [5];
    logic [19:0] m;
    for (int g = 0; g < 5; g++) lat[g] = -1;
    @(negedge clk);
    opw = op; aw = a; bw = b; ivw = 1'b1;
    chk("in_ready_w", irw, 5'h1f);
    @(posedge clk);
    @(negedge clk);
    ivw = 1'b0; opw = ~op; aw = ~a; bw = ~b;
    n = 0;
    forever begin
      for (int g = 0; g < 5; g++) if (ovw[g] && lat[g] < 0) lat[g] = n;
      if (&ovw || n >= 40) break;
      @(negedge clk);
      n++;
    end
    m = model(op, a, b);
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("latency_c%0d", chs[g]), lat[g], 16 / chs[g]);
      chk($sformatf("result_c%0d", chs[g]), resw[g], m[15:0]);
      chk($sformatf("carry_c%0d", chs[g]), cw[g], m[19]);
      chk($sformatf("ovf_c%0d", chs[g]), vw[g], m[18]);
      chk($sformatf("zero_c%0d", chs[g]), zw[g], m[17]);
      chk($sformatf("neg_c%0d", chs[g]), nw[g], m[16]);
    end
    orw = 1'b1;
    @(negedge clk);
    orw = 1'b0;
    chk("pop_w_valid", ovw, 5'h00);
    chk("pop_w_ready", irw, 5'h1f);
  endtask

  initial begin
    logic [7:0] hold;
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
    ivw = 1'b0; orw = 1'b0; opw = 1'b0; aw = '0; bw = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_result", res8, 8'h00);
    chk("rst_flags", {c8, v8, z8, n8}, 4'b0000);
    chk("rst_w_valid", ovw, 5'h00);
    rst_n = 1'b1;

    go8(1'b1, 8'h50, 8'h30); res8_chk(8'h20, 0, 0, 0, 0); pop8();
    go8(1'b1, 8'h30, 8'h50); res8_chk(8'hE0, 1, 0, 0, 1); pop8();
    go8(1'b1, 8'h80, 8'h01); res8_chk(8'h7F, 0, 1, 0, 0); pop8();
    go8(1'b0, 8'h7F, 8'h01); res8_chk(8'h80, 0, 1, 0, 1); pop8();
    go8(1'b0, 8'hFF, 8'h01); res8_chk(8'h00, 1, 0, 1, 0); pop8();

    // Backpressure: outputs must hold while in_valid and operands wiggle.
    go8(1'b0, 8'h3C, 8'h25);
    hold = 8'h61;
    for (int i = 0; i < 5; i++) begin
      iv8 = ~iv8; a8 = 8'($urandom); b8 = 8'($urandom); op8 = ~op8;
      @(negedge clk);
      chk("bp_result", res8, hold);
      chk("bp_in_ready", ir8, 0);
      chk("bp_out_valid", ov8, 1);
    end
    iv8 = 1'b0;
    pop8();

    // Reset in the first RUN cycle discards the op entirely.
    @(negedge clk);
    op8 = 1'b0; a8 = 8'h12; b8 = 8'h34; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_valid", ov8, 0);
    chk("midrun_rst_ready", ir8, 1);
    chk("midrun_rst_result", res8, 8'h00);
    chk("midrun_rst_flags", {c8, v8, z8, n8}, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_emit_after_rst", ov8, 0);
    end
    go8(1'b0, 8'h12, 8'h34); res8_chk(8'h46, 0, 0, 0, 0); pop8();

    go16(1'b1, 16'h1000, 16'h0001);
    chk("w4_borrow_chain", resw[2], 16'h0FFF);
    go16(1'b0, 16'hFFFF, 16'h0001);
    go16(1'b0, 16'h7FFF, 16'h0001);
    go16(1'b1, 16'h8000, 16'h0001);
    go16(1'b1, 16'h0001, 16'h0002);
    for (int i = 0; i < 12; i++)
      go16(1'($urandom), 16'($urandom), 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
